// File: rtl/clause_verifier_if.sv
// ---------------------------------------------------------------------------
// clause_verifier_if
// Purpose : groups the clause-table write port, the check request and the
//           check result of clause_verifier into one bundle.
// Signals : wr_en/wr_addr/wr_pos/wr_neg - clause-table write
//           start/assignment             - check request
//           busy/done/sat/fail_idx       - check status/result
//           dbg_state                    - FSM state (debug observation)
// Modports: master drives requests and writes, slave is the verifier.
// Handshake: a write is taken on any rising edge where wr_en=1 and busy=0;
//           a start is taken only on an edge where the verifier is idle;
//           done is a one-cycle pulse, sat/fail_idx hold until the next start.
// ---------------------------------------------------------------------------
interface clause_verifier_if #(
    parameter int N = 32,
    parameter int M = 4
);
    localparam int AW = $clog2(M);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_pos;
    logic [N-1:0]  wr_neg;
    logic          start;
    logic [N-1:0]  assignment;
    logic          busy;
    logic          done;
    logic          sat;
    logic [AW-1:0] fail_idx;
    logic [1:0]    dbg_state;

    modport master (
        output wr_en, wr_addr, wr_pos, wr_neg, start, assignment,
        input  busy, done, sat, fail_idx, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_pos, wr_neg, start, assignment,
        output busy, done, sat, fail_idx, dbg_state
    );
endinterface

// File: rtl/clause_verifier.sv
// ---------------------------------------------------------------------------
// clause_verifier
// Purpose : sequential 3SAT solution checker. Holds M clauses as positive and
//           negative literal masks, latches a candidate assignment on start,
//           evaluates one clause per cycle and reports whether all clauses
//           are satisfied plus the index of the first unsatisfied clause.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-high; clears FSM, outputs, table
//           bus   - clause_verifier_if.slave (write port, start/assignment,
//                   busy/done/sat/fail_idx, dbg_state)
// Options : CLAUSE_VERIFIER_EARLY_EXIT_EN - when defined, the scan stops at the
//           first unsatisfied clause; otherwise all M clauses are scanned.
// ---------------------------------------------------------------------------
module clause_verifier #(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic               clk,
    input  logic               reset,
    clause_verifier_if.slave   bus
);
    localparam int AW = $clog2(M);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [N-1:0]  r_pos [M];
    logic [N-1:0]  r_neg [M];
    logic [N-1:0]  r_assign;
    logic [AW-1:0] r_idx;
    logic          r_miss;
    logic          r_sat;
    logic [AW-1:0] r_fail_idx;

    logic          w_busy;
    logic          w_wr_ok;
    logic          w_clause_sat;
    logic          w_last;
    logic          w_stop_early;

    // busy/done are decodes of the state register, so they carry no path
    // from any input.
    assign w_busy = (r_state == S_SCAN);

    assign w_wr_ok = bus.wr_en && !w_busy && (32'(bus.wr_addr) < M);

    // An all-zero entry yields 0 here, so an empty clause is never satisfied.
    assign w_clause_sat = (|(r_pos[r_idx] & r_assign)) | (|(r_neg[r_idx] & ~r_assign));
    assign w_last       = (r_idx == AW'(M - 1));

`ifdef CLAUSE_VERIFIER_EARLY_EXIT_EN
    assign w_stop_early = !w_clause_sat;
`else
    assign w_stop_early = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last || w_stop_early) begin
                    w_next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Clause table. Writes are blocked only while scanning, so a write on the
    // same idle edge as start is visible to the first clause evaluation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < M; i++) begin
                r_pos[i] <= '0;
                r_neg[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_pos[bus.wr_addr] <= bus.wr_pos;
            r_neg[bus.wr_addr] <= bus.wr_neg;
        end
    end

    // Scan datapath and held results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_assign   <= '0;
            r_idx      <= '0;
            r_miss     <= 1'b0;
            r_sat      <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_assign   <= bus.assignment;
                        r_idx      <= '0;
                        r_miss     <= 1'b0;
                        r_sat      <= 1'b0;
                        r_fail_idx <= '0;
                    end
                end
                S_SCAN: begin
                    // Only the first miss is recorded; later misses are
                    // still scanned in the full-scan build but ignored.
                    if (!w_clause_sat && !r_miss) begin
                        r_miss     <= 1'b1;
                        r_fail_idx <= r_idx;
                    end
                    if (w_next_state == S_REPORT) begin
                        r_sat <= !r_miss && w_clause_sat;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = (r_state == S_REPORT);
    assign bus.sat       = r_sat;
    assign bus.fail_idx  = r_fail_idx;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_clause_verifier.sv
module tb_clause_verifier;
    localparam int N = 4;
    localparam int M = 4;

`ifdef CLAUSE_VERIFIER_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    clause_verifier_if #(.N(N), .M(M)) bus ();

    clause_verifier #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_clause(input logic [1:0] addr, input logic [3:0] pos, input logic [3:0] neg);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_pos  = pos;
        bus.wr_neg  = neg;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Launch a check, optionally disturbing it with a dropped write and stray
    // start pulses, then measure edges from E0 to the done pulse.
    task automatic run_check(input string tag, input logic [3:0] a, input logic exp_sat,
                             input logic [1:0] exp_fail, input int exp_lat, input logic disturb);
        int  lat;
        int  extra;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.assignment = a;
        @(posedge clk);                    // E0
        #1;
        bus.start      = disturb;
        bus.assignment = ~a;               // latched copy must not follow this
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_clr_sat"}, 32'(bus.sat), 32'd0);
        if (disturb) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 2'd1;
            bus.wr_pos  = 4'b0000;
            bus.wr_neg  = 4'b0000;
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) bus.wr_en = 1'b0;
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        bus.wr_en = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
        check({tag, "_fail_idx"}, 32'(bus.fail_idx), 32'(exp_fail));
        check({tag, "_busy_rpt"}, 32'(bus.busy), 32'd0);
        // start during REPORT must be ignored
        bus.start = disturb;
        extra = 0;
        for (int k = 0; k < M + 3; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) extra++;
        end
        check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
        check({tag, "_hold_sat"}, 32'(bus.sat), 32'(exp_sat));
        check({tag, "_hold_fail"}, 32'(bus.fail_idx), 32'(exp_fail));
        check({tag, "_idle"}, 32'(bus.dbg_state), 32'd0);
    endtask

    initial begin
        int dones;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_pos     = '0;
        bus.wr_neg     = '0;
        bus.start      = 1'b0;
        bus.assignment = '0;

        // Reset state
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);
        check("rst_fail", 32'(bus.fail_idx), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Empty table: clause 0 is empty and fails first
        run_check("empty", 4'b1010, 1'b0, 2'd0, EARLY ? 1 : 4, 1'b0);

        // Load x0|~x3, x1|~x0, x2|~x1, x3|~x2
        write_clause(2'd0, 4'b0001, 4'b1000);
        write_clause(2'd1, 4'b0010, 4'b0001);
        write_clause(2'd2, 4'b0100, 4'b0010);
        write_clause(2'd3, 4'b1000, 4'b0100);

        run_check("a1111", 4'b1111, 1'b1, 2'd0, 4, 1'b0);
        run_check("a0000", 4'b0000, 1'b1, 2'd0, 4, 1'b0);
        run_check("a0001", 4'b0001, 1'b0, 2'd1, EARLY ? 2 : 4, 1'b0);
        run_check("a0100", 4'b0100, 1'b0, 2'd3, 4, 1'b0);

        // Write while busy is dropped, stray starts are ignored
        run_check("busywr", 4'b1111, 1'b1, 2'd0, 4, 1'b1);
        run_check("rerun", 4'b1111, 1'b1, 2'd0, 4, 1'b0);

        // Reset at E0+2 of a scan
        @(negedge clk);
        bus.start      = 1'b1;
        bus.assignment = 4'b1111;
        @(posedge clk);                    // E0
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);                    // E0+2
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_sat", 32'(bus.sat), 32'd0);
        check("mid_rst_fail", 32'(bus.fail_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < M + 2; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);

        // Table was zeroed: clause 0 is empty again
        run_check("post_rst", 4'b1111, 1'b0, 2'd0, EARLY ? 1 : 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends on its own
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clause_verifier.md
# clause_verifier

Sequential 3SAT solution checker that sits on the consumer side of the `schoening` solver. It holds a loadable clause table as a positive-literal mask and a negative-literal mask per clause. It accepts a candidate assignment, such as the solver's `solution` when `done` rises, and scans the clauses one per cycle. It reports whether every clause is satisfied and, if not, the index of the first unsatisfied clause.

## Interface
- `N`, 32, number of variables; width of assignment and literal masks.
- `M`, 4, number of clauses; must be ≥ 2. `AW = log2c(M)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: clause-table write strobe.
- `wr_addr` in AW: clause index to write.
- `wr_pos` in N: positive-literal mask; bit v set means literal x_v.
- `wr_neg` in N: negative-literal mask; bit v set means literal ~x_v.
- `start` in 1: begin a check of `assignment`.
- `assignment` in N: candidate variable values.
- `busy` out 1: high while a check is in progress.
- `done` out 1: one-cycle pulse when a result is valid.
- `sat` out 1: 1 if all clauses are satisfied. Valid from `done` until the next accepted `start`.
- `fail_idx` out AW: index of the first unsatisfied clause. 0 when `sat`=1.

## Operation
- Clause table: M entries of {pos, neg}. A clause is satisfied iff `|(pos & a) | |(neg & ~a)`. An all-zero entry (empty clause) is always unsatisfied.
- Write:
  - Accepted on a rising edge with `wr_en`=1, `busy`=0 and `wr_addr` < M.
  - Writes while `busy`=1, or with `wr_addr` ≥ M, are dropped silently.
- FSM states:
  - IDLE:
    - `start`=1 latches `assignment` into an internal register, sets idx=0 and `busy`=1, and moves to SCAN.
    - `start` while not in IDLE is ignored.
  - SCAN: evaluates clause idx against the latched assignment.
    - Unsatisfied and it is the first miss: record `fail_idx`=idx.
    - Move to REPORT when idx = M-1, or when the clause is unsatisfied and early exit is compiled in (see Configuration).
    - Otherwise idx increments.
  - REPORT:
    - `done`=1 for exactly one cycle. `sat` = (no miss recorded).
    - `busy`=0 in this cycle; next state is IDLE.
    - A `start` in REPORT is ignored.
- `sat` and `fail_idx` hold their value through IDLE until the next accepted `start`. Both are cleared to 0 at that edge.
- A write and a `start` on the same IDLE edge: the write lands first, and the scan sees the new entry.
- The latched assignment is immune to `assignment` changes during the scan.

## Timing
- Reset (asynchronous): FSM to IDLE.
  - All outputs go to 0: `busy`=0, `done`=0, `sat`=0, `fail_idx`=0.
  - All clause entries are cleared to zero.
  - Reset mid-scan aborts with no `done` pulse.
- `start` is sampled at edge E0. `busy` is high from after E0.
- Clause k is evaluated in the cycle after edge E0+k.
- Full scan: REPORT is entered at edge E0+M. `done` is high during cycle E0+M → E0+M+1. Throughput is one check per M+2 edges.
- Early exit at clause j: `done` is high after edge E0+j+1.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- `CLAUSE_VERIFIER_EARLY_EXIT_EN` defined: SCAN terminates on the first unsatisfied clause. Latency is data-dependent.
- Undefined: all M clauses are always scanned. Latency is fixed at M edges to REPORT. `fail_idx` is still the first miss, and `sat`/`fail_idx` values are identical in both builds.

## Test plan
Default bench: N=4, M=4. Load clauses 0..3 as pos/neg = {0001/1000, 0010/0001, 0100/0010, 1000/0100}, giving x0|~x3, x1|~x0, x2|~x1, x3|~x2.
- Assignment 1111, then 0000 -> `sat`=1, `fail_idx`=0, `done` after edge E0+4 in both builds.
- Assignment 0001 -> `sat`=0, `fail_idx`=1.
  - With EN: `done` after E0+2.
  - Without EN: `done` after E0+4.
- Assignment 0100 -> `sat`=0, `fail_idx`=3, `done` after E0+4.
- No writes after reset, assignment 1010 -> `sat`=0, `fail_idx`=0 (empty clause).
- Write clause 1 = 0000/0000 while `busy`=1, then rerun 1111 -> write dropped, `sat`=1. `start` pulses during SCAN/REPORT produce no extra `done`.
- Assert `reset` at E0+2 of a scan -> outputs 0 immediately, no `done`, table zeroed. The next `start` with 1111 gives `sat`=0, `fail_idx`=0.
